// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// trial subtraction through a ripple chain of full_adder cells.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_sh_c;
  logic [WIDTH:0]   sub_c;
  logic [WIDTH:0]   t_c;
  logic [WIDTH+1:0] cy_c;
  logic             nonneg_c;
  logic [WIDTH-1:0] dvd_mag_c;
  logic [WIDTH-1:0] dvs_mag_c;

  // Trial subtract: T = {R,msb} - {0,|divisor|} as A + ~B + 1
  assign r_sh_c  = {r_q, q_q[WIDTH-1]};
  assign sub_c   = ~{1'b0, dvs_q};
  assign cy_c[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a   (r_sh_c[i]),
      .b   (sub_c[i]),
      .cin (cy_c[i]),
      .s   (t_c[i]),
      .cout(cy_c[i+1])
    );
  end

  // No borrow out and a clear sign bit both mean T >= 0
  assign nonneg_c = cy_c[WIDTH+1] & ~t_c[WIDTH];

  assign dvd_mag_c = (is_signed && dividend[WIDTH-1]) ? WIDTH'(-dividend) : dividend;
  assign dvs_mag_c = (is_signed && divisor[WIDTH-1])  ? WIDTH'(-divisor)  : divisor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          negq_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d = is_signed & dividend[WIDTH-1];
          r_d    = '0;
          cnt_d  = '0;
          dvs_d  = dvs_mag_c;
          if (divisor == '0) begin
            // Q carries the raw dividend through to the remainder output
            zero_d  = 1'b1;
            q_d     = dividend;
            state_d = FIX;
          end else begin
            zero_d  = 1'b0;
            q_d     = dvd_mag_c;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // A kept value is below |divisor|, so its top bit is always zero
        r_d   = nonneg_c ? t_c[WIDTH-1:0] : r_sh_c[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], nonneg_c};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (zero_q) begin
          quot_d = '1;
          rem_d  = q_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = negq_q ? WIDTH'(-q_q) : q_q;
          rem_d  = negr_q ? WIDTH'(-r_q) : r_q;
          dbz_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
